lcd_video_capture: RTL and testbench

//  Receive side of the LCD pixel interface: consumes hs_n/vs_n/data_enable plus pixel data
//  as produced by the panel timing generator, or by an external source with the same timing,
//  and recovers x/y. Emits a frame-buffer write stream (address = y*H_ACT + x).

---
 rtl/lcd_video_capture.sv | 221 ++++++++++++++++++++++
 tb/tb_lcd_video_capture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_video_capture.sv
// LCD receive path: recovers x/y from hs_n/vs_n/data_enable timing, verifies line/frame
// geometry and emits a frame-buffer write stream only while locked to a clean stream.
module lcd_video_capture #(
    parameter int H_ACT       = 800,
    parameter int V_ACT       = 480,
    parameter int DATA_W      = 24,
    parameter int ADDR_W      = 22,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              hs_n,
    input  logic              vs_n,
    input  logic              data_enable,
    input  logic [DATA_W-1:0] pixel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_address,
    output logic [DATA_W-1:0] wr_data,
    output logic              locked,
    output logic              frame_done,
    output logic              line_error,
    output logic              frame_error,
    output logic [10:0]       h_total_meas
);

    localparam int X_W = $clog2(H_ACT + 1);
    localparam int Y_W = $clog2(V_ACT + 2);
    localparam int G_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [X_W-1:0] X_MAX  = X_W'(H_ACT);
    localparam logic [Y_W-1:0] Y_ACT  = Y_W'(V_ACT);
    localparam logic [Y_W-1:0] Y_SAT  = Y_W'(V_ACT + 1);
    localparam logic [G_W-1:0] G_LOCK = G_W'(LOCK_FRAMES);
    localparam logic [10:0]    H_SAT  = 11'd2047;

    typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [G_W-1:0]    good_cnt_q, good_cnt_d;
    logic [10:0]       h_cnt_q, h_cnt_d;
    logic              frame_bad_q, frame_bad_d;
    logic              overlong_q, overlong_d;
    logic              hs_prev_q, hs_prev_d;
    logic              vs_prev_q, vs_prev_d;
    logic              de_prev_q, de_prev_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_address_q, wr_address_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              locked_q, locked_d;
    logic              frame_done_q, frame_done_d;
    logic              line_error_q, line_error_d;
    logic              frame_error_q, frame_error_d;
    logic [10:0]       h_total_meas_q, h_total_meas_d;
    logic              vs_fall_s, hs_fall_s, de_fall_s, frame_good_s;

    assign vs_fall_s = tick & vs_prev_q & ~vs_n;
    assign hs_fall_s = tick & hs_prev_q & ~hs_n;
    assign de_fall_s = tick & de_prev_q & ~data_enable;

    // Per tick: close the line, then the frame boundary, then the pixel, so coincident events compose.
    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        good_cnt_d     = good_cnt_q;
        h_cnt_d        = h_cnt_q;
        frame_bad_d    = frame_bad_q;
        overlong_d     = overlong_q;
        hs_prev_d      = hs_prev_q;
        vs_prev_d      = vs_prev_q;
        de_prev_d      = de_prev_q;
        wr_en_d        = 1'b0;
        wr_address_d   = wr_address_q;
        wr_data_d      = wr_data_q;
        frame_done_d   = 1'b0;
        line_error_d   = 1'b0;
        frame_error_d  = 1'b0;
        h_total_meas_d = h_total_meas_q;
        frame_good_s   = 1'b0;
        if (tick) begin
            hs_prev_d = hs_n;
            vs_prev_d = vs_n;
            de_prev_d = data_enable;
            if (hs_fall_s) begin
                h_total_meas_d = (h_cnt_q == H_SAT) ? H_SAT : h_cnt_q + 11'd1;
                h_cnt_d        = 11'd0;
            end else begin
                h_cnt_d = (h_cnt_q == H_SAT) ? H_SAT : h_cnt_q + 11'd1;
            end
            if (de_fall_s) begin
                if ((x_q != X_MAX) || overlong_q) begin
                    line_error_d = 1'b1;
                    frame_bad_d  = 1'b1;
                end else begin
                    line_error_d = 1'b0;
                end
                y_d        = (y_q == Y_SAT) ? y_q : y_q + {{(Y_W-1){1'b0}}, 1'b1};
                x_d        = {X_W{1'b0}};
                overlong_d = 1'b0;
            end else begin
                overlong_d = overlong_q;
            end
            if (vs_fall_s) begin
                frame_good_s = (y_d == Y_ACT) && !frame_bad_d;
                case (state_q)
                    SEARCH: begin
                        state_d    = CHECK;
                        good_cnt_d = {G_W{1'b0}};
                    end
                    CHECK: begin
                        if (frame_good_s) begin
                            good_cnt_d = good_cnt_q + {{(G_W-1){1'b0}}, 1'b1};
                            state_d    = (good_cnt_d == G_LOCK) ? LOCKED : CHECK;
                        end else begin
                            good_cnt_d    = {G_W{1'b0}};
                            frame_error_d = 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (frame_good_s) begin
                            frame_done_d = 1'b1;
                        end else begin
                            frame_error_d = 1'b1;
                            state_d       = CHECK;
                            good_cnt_d    = {G_W{1'b0}};
                        end
                    end
                    default: begin
                        state_d    = SEARCH;
                        good_cnt_d = {G_W{1'b0}};
                    end
                endcase
                x_d         = {X_W{1'b0}};
                y_d         = {Y_W{1'b0}};
                frame_bad_d = 1'b0;
                overlong_d  = 1'b0;
            end else begin
                frame_good_s = 1'b0;
            end
            if (data_enable) begin
                if (y_d >= Y_ACT) begin
                    frame_bad_d = 1'b1;
                end else begin
                    frame_bad_d = frame_bad_d;
                end
                if (x_d < X_MAX) begin
                    if ((y_d < Y_ACT) && (state_d == LOCKED) && !frame_bad_d) begin
                        wr_en_d      = 1'b1;
                        wr_address_d = ADDR_W'(y_d) * ADDR_W'(H_ACT) + ADDR_W'(x_d);
                        wr_data_d    = pixel;
                    end else begin
                        wr_en_d = 1'b0;
                    end
                    x_d = x_d + {{(X_W-1){1'b0}}, 1'b1};
                end else begin
                    overlong_d = 1'b1;
                end
            end else begin
                wr_en_d = 1'b0;
            end
        end else begin
            state_d = state_q;
        end
        locked_d = (state_d == LOCKED);
    end

    // Capture state and registered outputs; reset_n clears everything immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= SEARCH;
            x_q            <= {X_W{1'b0}};
            y_q            <= {Y_W{1'b0}};
            good_cnt_q     <= {G_W{1'b0}};
            h_cnt_q        <= 11'd0;
            frame_bad_q    <= 1'b0;
            overlong_q     <= 1'b0;
            hs_prev_q      <= 1'b1;
            vs_prev_q      <= 1'b1;
            de_prev_q      <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_address_q   <= {ADDR_W{1'b0}};
            wr_data_q      <= {DATA_W{1'b0}};
            locked_q       <= 1'b0;
            frame_done_q   <= 1'b0;
            line_error_q   <= 1'b0;
            frame_error_q  <= 1'b0;
            h_total_meas_q <= 11'd0;
        end else begin
            state_q        <= state_d;
            x_q            <= x_d;
            y_q            <= y_d;
            good_cnt_q     <= good_cnt_d;
            h_cnt_q        <= h_cnt_d;
            frame_bad_q    <= frame_bad_d;
            overlong_q     <= overlong_d;
            hs_prev_q      <= hs_prev_d;
            vs_prev_q      <= vs_prev_d;
            de_prev_q      <= de_prev_d;
            wr_en_q        <= wr_en_d;
            wr_address_q   <= wr_address_d;
            wr_data_q      <= wr_data_d;
            locked_q       <= locked_d;
            frame_done_q   <= frame_done_d;
            line_error_q   <= line_error_d;
            frame_error_q  <= frame_error_d;
            h_total_meas_q <= h_total_meas_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_address   = wr_address_q;
    assign wr_data      = wr_data_q;
    assign locked       = locked_q;
    assign frame_done   = frame_done_q;
    assign line_error   = line_error_q;
    assign frame_error  = frame_error_q;
    assign h_total_meas = h_total_meas_q;

endmodule

// File: tb/tb_lcd_video_capture.sv
// Directed bench for lcd_video_capture on a reduced 8x4 raster: lock, writes, geometry
// errors, mid-frame reset and sparse-tick operation, with a write scoreboard.
module tb_lcd_video_capture;

    localparam int H_ACT = 8;
    localparam int V_ACT = 4;
    localparam int DATA_W = 24;
    localparam int ADDR_W = 6;
    localparam int LOCK_FRAMES = 2;
    localparam int HS = 2;
    localparam int HBP = 3;
    localparam int HT = 16;
    localparam int VS = 1;
    localparam int VBP = 1;
    localparam int VFP = 1;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              tick;
    logic              hs_n;
    logic              vs_n;
    logic              data_enable;
    logic [DATA_W-1:0] pixel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_address;
    logic [DATA_W-1:0] wr_data;
    logic              locked;
    logic              frame_done;
    logic              line_error;
    logic              frame_error;
    logic [10:0]       h_total_meas;

    int checks = 0;
    int failures = 0;
    int div = 1;
    int fno = 0;
    int le_cnt = 0;
    int fe_cnt = 0;
    int fd_cnt = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    always #5 clock = ~clock;

    lcd_video_capture #(
        .H_ACT(H_ACT), .V_ACT(V_ACT), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clock(clock), .reset_n(reset_n), .tick(tick), .hs_n(hs_n), .vs_n(vs_n),
        .data_enable(data_enable), .pixel(pixel), .wr_en(wr_en), .wr_address(wr_address),
        .wr_data(wr_data), .locked(locked), .frame_done(frame_done), .line_error(line_error),
        .frame_error(frame_error), .h_total_meas(h_total_meas)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sampled each negedge: tallies pulses and pops the scoreboard on every write.
    task automatic observe();
        logic [ADDR_W+DATA_W-1:0] e;
        if (line_error === 1'b1) le_cnt++;
        if (frame_error === 1'b1) fe_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
        if (wr_en === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_write observed_addr=%0d expected=none", wr_address);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("f%0d_write_addr", fno), 32'(wr_address), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                chk($sformatf("f%0d_write_data", fno), 32'(wr_data), 32'(e[DATA_W-1:0]));
            end
        end
    endtask

    task automatic cycle(input logic t, input logic hs, input logic vs, input logic de,
                         input logic [DATA_W-1:0] pix);
        @(negedge clock);
        observe();
        tick = t;
        hs_n = hs;
        vs_n = vs;
        data_enable = de;
        pixel = pix;
    endtask

    // Non-tick clocks carry random garbage that the DUT must ignore.
    task automatic step(input logic hs, input logic vs, input logic de, input logic [DATA_W-1:0] pix);
        for (int k = 0; k < div - 1; k++)
            cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), DATA_W'($urandom));
        cycle(1'b1, hs, vs, de, pix);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_address"}, 32'(wr_address), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_line_error"}, 32'(line_error), 32'd0);
        chk({tag, "_frame_error"}, 32'(frame_error), 32'd0);
        chk({tag, "_h_total"}, 32'(h_total_meas), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        observe();
        chk("queue_at_reset", exp_q.size(), 32'd0);
        tick = 1'b0;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic frame(input int act, input int odd_line, input int odd_len, input bit exp_wr,
                         input int wr_limit, input int rst_line,
                         input int e_le, input int e_fe, input int e_fd, input int e_lk);
        int le0;
        int fe0;
        int fd0;
        bit wr;
        fno++;
        le0 = le_cnt;
        fe0 = fe_cnt;
        fd0 = fd_cnt;
        wr = exp_wr;
        for (int l = 0; l < VS + VBP + act + VFP; l++) begin
            int a;
            int len;
            a = l - VS - VBP;
            len = (a == odd_line) ? odd_len : H_ACT;
            if (l >= VS + VBP && a == rst_line) begin
                do_reset();
                wr = 1'b0;
            end
            for (int t = 0; t < HT; t++) begin
                int px;
                logic de;
                logic [DATA_W-1:0] pix;
                px = t - HS - HBP;
                de = (a >= 0) && (a < act) && (px >= 0) && (px < len);
                pix = DATA_W'($urandom);
                if (de && wr && (a < wr_limit) && (px < H_ACT))
                    exp_q.push_back({ADDR_W'(a * H_ACT + px), pix});
                step(t >= HS, l >= VS, de, pix);
            end
        end
        chk($sformatf("f%0d_writes_outstanding", fno), exp_q.size(), 32'd0);
        chk($sformatf("f%0d_line_error", fno), le_cnt - le0, e_le);
        chk($sformatf("f%0d_frame_error", fno), fe_cnt - fe0, e_fe);
        chk($sformatf("f%0d_frame_done", fno), fd_cnt - fd0, e_fd);
        chk($sformatf("f%0d_locked", fno), 32'(locked), e_lk);
        exp_q.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        tick = 1'b0;
        hs_n = 1'b1;
        vs_n = 1'b1;
        data_enable = 1'b0;
        pixel = {DATA_W{1'b0}};
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset_n = 1'b1;

        // Acquisition: lock on the third vs_fall, then full frames of writes.
        frame(4, -1, 0, 1'b0, V_ACT, -1, 0, 0, 0, 0);
        frame(4, -1, 0, 1'b0, V_ACT, -1, 0, 0, 0, 0);
        frame(4, -1, 0, 1'b1, V_ACT, -1, 0, 0, 0, 1);
        frame(4, -1, 0, 1'b1, V_ACT, -1, 0, 0, 1, 1);
        chk("h_total_meas", 32'(h_total_meas), HT);

        // Short line while locked.
        frame(4, 1, H_ACT - 1, 1'b1, 2, -1, 1, 0, 1, 1);
        frame(4, -1, 0, 1'b0, V_ACT, -1, 0, 1, 0, 0);
        frame(4, -1, 0, 1'b0, V_ACT, -1, 0, 0, 0, 0);
        frame(4, -1, 0, 1'b1, V_ACT, -1, 0, 0, 0, 1);

        // Overlong line while locked.
        frame(4, 2, H_ACT + 1, 1'b1, 3, -1, 1, 0, 1, 1);
        frame(4, -1, 0, 1'b0, V_ACT, -1, 0, 1, 0, 0);
        frame(4, -1, 0, 1'b0, V_ACT, -1, 0, 0, 0, 0);
        frame(4, -1, 0, 1'b1, V_ACT, -1, 0, 0, 0, 1);

        // One active line too many.
        frame(5, -1, 0, 1'b1, V_ACT, -1, 0, 0, 1, 1);
        frame(4, -1, 0, 1'b0, V_ACT, -1, 0, 1, 0, 0);
        frame(4, -1, 0, 1'b0, V_ACT, -1, 0, 0, 0, 0);
        frame(4, -1, 0, 1'b1, V_ACT, -1, 0, 0, 0, 1);

        // Reset mid-frame while locked, then relock.
        frame(4, -1, 0, 1'b1, V_ACT, 2, 0, 0, 1, 0);
        frame(4, -1, 0, 1'b0, V_ACT, -1, 0, 0, 0, 0);
        frame(4, -1, 0, 1'b0, V_ACT, -1, 0, 0, 0, 0);
        frame(4, -1, 0, 1'b1, V_ACT, -1, 0, 0, 0, 1);

        // Tick every third clock with glitching inputs in between: same results as acquisition.
        div = 3;
        do_reset();
        frame(4, -1, 0, 1'b0, V_ACT, -1, 0, 0, 0, 0);
        frame(4, -1, 0, 1'b0, V_ACT, -1, 0, 0, 0, 0);
        frame(4, -1, 0, 1'b1, V_ACT, -1, 0, 0, 0, 1);
        frame(4, -1, 0, 1'b1, V_ACT, -1, 0, 0, 1, 1);
        chk("h_total_meas_sparse", 32'(h_total_meas), HT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
